pipeline_hazard_ctl: RTL

//  Central stall/flush sequencer for the 5-stage pipeline. Watches the ID and EX

---
 rtl/pipeline_hazard_ctl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// It resolves three kinds of event:
//  - data-memory wait states, which freeze the front of the pipe;
//  - taken-branch flushes;
//  - load-use hazards.
// It also keeps saturating stall and flush counters.
module pipeline_hazard_ctl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rt,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             idex_hold,
  output logic             exmem_flush,
  output logic             exmem_hold,
  output logic             memwb_bubble,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned TMO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN,
    LU_STALL,
    FLUSH,
    MEM_WAIT
  } state_t;

  state_t           state, state_nx;
  logic             pending_br, pending_br_nx;
  logic [TMO_W-1:0] tmo, tmo_nx;
  logic             mem_err_nx;
  logic             flush_evt;
  logic             lu;

  // Load-use hazard: a load in EX writes a register that the instruction in ID reads.
  always_comb begin
    lu = idex_mem_read && (idex_rt != '0) &&
         ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
  end

  // Next-state logic and pipeline control outputs.
  always_comb begin
    state_nx      = state;
    pending_br_nx = pending_br;
    tmo_nx        = tmo;
    mem_err_nx    = mem_err;
    flush_evt     = 1'b0;
    pc_write      = 1'b1;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    idex_hold     = 1'b0;
    exmem_flush   = 1'b0;
    exmem_hold    = 1'b0;
    memwb_bubble  = 1'b0;

    if (rst) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_flush  = 1'b1;
      memwb_bubble = 1'b1;
    end else begin
      case (state)
        MEM_WAIT: begin
          if (dmem_ready) begin
            // Access completes: release the freeze this cycle.
            // Replay any branch that arrived while frozen.
            tmo_nx = '0;
            if (pending_br) begin
              ifid_flush    = 1'b1;
              idex_bubble   = 1'b1;
              exmem_flush   = 1'b1;
              flush_evt     = 1'b1;
              pending_br_nx = 1'b0;
              state_nx      = FLUSH;
            end else begin
              state_nx = RUN;
            end
          end else begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_hold    = 1'b1;
            exmem_hold   = 1'b1;
            memwb_bubble = 1'b1;
            if (tmo == TMO_W'(MEM_TIMEOUT)) begin
              mem_err_nx    = 1'b1;
              tmo_nx        = '0;
              pending_br_nx = 1'b0;
              state_nx      = RUN;
            end else begin
              tmo_nx = tmo + TMO_W'(1);
            end
          end
        end
        default: begin
          // RUN, LU_STALL and FLUSH share one event handler.
          // Load-use is only honoured in RUN: after a stall or flush, ID holds a replayed instruction or a NOP.
          state_nx = RUN;
          if (dmem_req && !dmem_ready) begin
            pc_write      = 1'b0;
            ifid_write    = 1'b0;
            idex_hold     = 1'b1;
            exmem_hold    = 1'b1;
            memwb_bubble  = 1'b1;
            tmo_nx        = TMO_W'(1);
            pending_br_nx = branch_taken;
            state_nx      = MEM_WAIT;
          end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
            flush_evt   = 1'b1;
            state_nx    = FLUSH;
          end else if (lu && (state == RUN)) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_nx    = LU_STALL;
          end
        end
      endcase
    end
  end

  // FSM state, pending branch, timeout counter and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      pending_br <= 1'b0;
      tmo        <= '0;
      mem_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      pending_br <= pending_br_nx;
      tmo        <= tmo_nx;
      mem_err    <= mem_err_nx;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_write && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_evt && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule
